if_id_hazard_reg: RTL and testbench

- IF/ID pipeline register plus hazard-response sequencer for the 5-stage CPU.
- Consumes IFstall/IDstall from the stall unit and branch resolution from EX.
- Acts on them: holds PC, freezes or bubbles IF/ID, injects an ID/EX NOP, and redirects fetch on taken branches.
- Keeps saturating stall/bubble counters for performance debug.

---
 rtl/if_id_hazard_reg.sv | 155 +++++++++++++++
 tb/tb_if_id_hazard_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with hazard-response sequencing.
// Turns the stall unit's IFstall/IDstall and EX branch resolution into
// PC hold/redirect controls, IF/ID freeze or NOP loads, ID/EX bubble
// injection, and saturating stall/bubble counters for performance debug.
module if_id_hazard_reg #(
  parameter int IW  = 32,
  parameter int PCW = 32,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           IFstall,
  input  logic           IDstall,
  input  logic           br_resolve,
  input  logic           br_taken,
  input  logic [PCW-1:0] br_target,
  input  logic [PCW-1:0] if_pc,
  input  logic [IW-1:0]  if_inst,
  output logic [PCW-1:0] id_pc,
  output logic [IW-1:0]  id_inst,
  output logic           id_valid,
  output logic           pc_hold,
  output logic           pc_sel,
  output logic [PCW-1:0] redir_pc,
  output logic           ex_bubble,
  output logic [CW-1:0]  stall_cnt,
  output logic [CW-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  state_t resolve_state;

  logic id_load_fetch;
  logic id_load_nop;
  logic capture_target;
  logic resolve_capture;

  logic [1:0]  bubble_inc;
  logic [CW:0] stall_sum;
  logic [CW:0] bubble_sum;

  // Outcome of a branch-wait cycle: resolve to REDIRECT/RUN or keep waiting
  always_comb begin
    resolve_state   = BR_WAIT;
    resolve_capture = 1'b0;
    if (br_resolve) begin
      resolve_state   = br_taken ? REDIRECT : RUN;
      resolve_capture = br_taken;
    end
  end

  // Hazard decode: data stall dominates, otherwise the sequencer state acts
  always_comb begin
    state_next     = state;
    id_load_fetch  = 1'b0;
    id_load_nop    = 1'b0;
    capture_target = 1'b0;
    pc_hold        = 1'b0;
    pc_sel         = 1'b0;
    ex_bubble      = 1'b0;
    if (!reset) begin
      if (IDstall) begin
        pc_hold   = 1'b1;
        ex_bubble = 1'b1;
        if (state == BR_WAIT) begin
          state_next     = resolve_state;
          capture_target = resolve_capture;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (IFstall) begin
              pc_hold        = 1'b1;
              id_load_nop    = 1'b1;
              state_next     = resolve_state;
              capture_target = resolve_capture;
            end else begin
              id_load_fetch = 1'b1;
            end
          end
          BR_WAIT: begin
            pc_hold        = 1'b1;
            id_load_nop    = 1'b1;
            state_next     = resolve_state;
            capture_target = resolve_capture;
          end
          REDIRECT: begin
            pc_sel      = 1'b1;
            id_load_nop = 1'b1;
            state_next  = RUN;
          end
          default: begin
            state_next = RUN;
          end
        endcase
      end
    end
  end

  // Sequencer state and captured branch target
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      redir_pc <= '0;
    end else begin
      state <= state_next;
      if (capture_target) begin
        redir_pc <= br_target;
      end
    end
  end

  // IF/ID register: fetch load, NOP load, or hold under a data stall
  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (id_load_fetch) begin
      id_pc    <= if_pc;
      id_inst  <= if_inst;
      id_valid <= 1'b1;
    end else if (id_load_nop) begin
      id_pc    <= if_pc;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end
  end

  // Counter increments; a carry into the top bit means the count would pass 2^CW-1
  always_comb begin
    bubble_inc = {1'b0, id_load_nop} + {1'b0, ex_bubble};
    stall_sum  = {1'b0, stall_cnt} + {{CW{1'b0}}, pc_hold};
    bubble_sum = {1'b0, bubble_cnt} + {{(CW - 1){1'b0}}, bubble_inc};
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= stall_sum[CW] ? {CW{1'b1}} : stall_sum[CW-1:0];
      bubble_cnt <= bubble_sum[CW] ? {CW{1'b1}} : bubble_sum[CW-1:0];
    end
  end

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Testbench for if_id_hazard_reg: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model. A second instance with
// CW=4 shares all inputs so counter saturation is exercised.
module tb_if_id_hazard_reg;

  logic        clk = 1'b0;
  logic        reset, IFstall, IDstall, br_resolve, br_taken;
  logic [31:0] br_target, if_pc, if_inst;

  logic [31:0] id_pc, id_inst, redir_pc;
  logic        id_valid, pc_hold, pc_sel, ex_bubble;
  logic [15:0] stall_cnt, bubble_cnt;

  logic [31:0] s_id_pc, s_id_inst, s_redir_pc;
  logic        s_id_valid, s_pc_hold, s_pc_sel, s_ex_bubble;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: pipeline contents plus two flags describing the branch episode
  logic [31:0] m_id_pc, m_id_inst, m_redir;
  bit          m_id_valid, m_wait, m_redirect;
  int          m_stall, m_bubble;
  bit          e_hold, e_sel, e_bubble, e_nop;

  always #5 clk = ~clk;

  if_id_hazard_reg #(.IW(32), .PCW(32), .CW(16)) dut (
    .clk(clk), .reset(reset), .IFstall(IFstall), .IDstall(IDstall),
    .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
    .if_pc(if_pc), .if_inst(if_inst), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .pc_hold(pc_hold), .pc_sel(pc_sel),
    .redir_pc(redir_pc), .ex_bubble(ex_bubble), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  if_id_hazard_reg #(.IW(32), .PCW(32), .CW(4)) dut_small (
    .clk(clk), .reset(reset), .IFstall(IFstall), .IDstall(IDstall),
    .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
    .if_pc(if_pc), .if_inst(if_inst), .id_pc(s_id_pc), .id_inst(s_id_inst),
    .id_valid(s_id_valid), .pc_hold(s_pc_hold), .pc_sel(s_pc_sel),
    .redir_pc(s_redir_pc), .ex_bubble(s_ex_bubble), .stall_cnt(s_stall_cnt),
    .bubble_cnt(s_bubble_cnt)
  );

  function automatic logic [15:0] sat16(int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [3:0] sat4(int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  // Expected combinational outputs for the current inputs and model state
  function automatic void model_comb();
    bit idle;
    idle = !m_wait && !m_redirect;
    if (reset) begin
      e_hold = 0; e_sel = 0; e_bubble = 0; e_nop = 0;
    end else begin
      e_bubble = IDstall;
      e_sel    = m_redirect && !IDstall;
      e_hold   = IDstall || m_wait || (idle && IFstall);
      e_nop    = !IDstall && (m_wait || m_redirect || (idle && IFstall));
    end
  endfunction

  // Drive one cycle of inputs, then move to mid-cycle for comb checks
  task automatic apply(input bit rst, input bit ifs, input bit ids, input bit brr,
                       input bit brt, input logic [31:0] tgt, input logic [31:0] pc,
                       input logic [31:0] inst);
    reset = rst; IFstall = ifs; IDstall = ids; br_resolve = brr; br_taken = brt;
    br_target = tgt; if_pc = pc; if_inst = inst;
    model_comb();
    @(negedge clk);
  endtask

  // Clock edge, then advance the model using the inputs that were sampled
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_redir = 0;
      m_wait = 0; m_redirect = 0; m_stall = 0; m_bubble = 0;
    end else begin
      m_stall  += int'(e_hold);
      m_bubble += int'(e_nop) + int'(e_bubble);
      if (IDstall) begin
        if (m_wait && br_resolve) begin
          m_wait = 0;
          if (br_taken) begin m_redirect = 1; m_redir = br_target; end
        end
      end else if (e_nop) begin
        m_id_pc = if_pc; m_id_inst = 0; m_id_valid = 0;
        if (m_redirect) m_redirect = 0;
        else if (br_resolve) begin
          m_wait = 0;
          if (br_taken) begin m_redirect = 1; m_redir = br_target; end
        end else m_wait = 1;
      end else begin
        m_id_pc = if_pc; m_id_inst = if_inst; m_id_valid = 1;
      end
    end
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 1, 32'hABC, 32'h10, 32'h1234);
    checks++; if ({pc_hold, pc_sel, ex_bubble} !== 3'b000) begin failures++;
      $display("[TB] FAIL reset_comb got=%b exp=000", {pc_hold, pc_sel, ex_bubble}); end
    tick();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0 || id_valid !== 1'b0) begin failures++;
      $display("[TB] FAIL reset_id got=%h/%h/%b exp=0/0/0", id_pc, id_inst, id_valid); end
    checks++; if (redir_pc !== 32'h0) begin failures++;
      $display("[TB] FAIL reset_redir got=%h exp=0", redir_pc); end
    checks++; if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin failures++;
      $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
    tick();
  endtask

  task automatic test_fetch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      checks++; if (pc_hold !== 1'b0) begin failures++;
        $display("[TB] FAIL fetch_hold got=%b exp=0", pc_hold); end
      tick();
      checks++; if (id_pc !== 32'h100 + 32'(4 * i) || id_valid !== 1'b1) begin failures++;
        $display("[TB] FAIL fetch_id got=%h/%b exp=%h/1", id_pc, id_valid, 32'h100 + 32'(4 * i)); end
      checks++; if (id_inst !== 32'h1000 + 32'(i)) begin failures++;
        $display("[TB] FAIL fetch_inst got=%h exp=%h", id_inst, 32'h1000 + 32'(i)); end
    end
    checks++; if (stall_cnt !== 16'd0) begin failures++;
      $display("[TB] FAIL fetch_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_id_stall();
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 32'h300, 32'h8C220004);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 1, 0, 0, 0, 32'h304, 32'hFFFF_FFFF);
      checks++; if (pc_hold !== 1'b1 || ex_bubble !== 1'b1) begin failures++;
        $display("[TB] FAIL idstall_comb got=%b/%b exp=1/1", pc_hold, ex_bubble); end
      tick();
      checks++; if (id_inst !== 32'h8C220004 || id_pc !== 32'h300) begin failures++;
        $display("[TB] FAIL idstall_hold got=%h/%h exp=8c220004/300", id_inst, id_pc); end
    end
    checks++; if (stall_cnt !== 16'd2 || bubble_cnt !== 16'd2) begin failures++;
      $display("[TB] FAIL idstall_cnt got=%0d/%0d exp=2/2", stall_cnt, bubble_cnt); end
  endtask

  task automatic test_branch(input bit taken);
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 32'h200, 32'h5555);
    checks++; if (pc_hold !== 1'b1 || pc_sel !== 1'b0) begin failures++;
      $display("[TB] FAIL br_ifstall got=%b/%b exp=1/0", pc_hold, pc_sel); end
    tick();
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h200 || id_inst !== 32'h0) begin failures++;
      $display("[TB] FAIL br_nop got=%b/%h/%h exp=0/200/0", id_valid, id_pc, id_inst); end
    apply(0, 1, 0, 0, 0, 0, 32'h204, 32'h6666);
    checks++; if (pc_hold !== 1'b1 || pc_sel !== 1'b0) begin failures++;
      $display("[TB] FAIL br_wait got=%b/%b exp=1/0", pc_hold, pc_sel); end
    tick();
    apply(0, 1, 0, 1, taken, 32'h400, 32'h204, 32'h6666);
    checks++; if (pc_hold !== 1'b1 || pc_sel !== 1'b0) begin failures++;
      $display("[TB] FAIL br_resolve got=%b/%b exp=1/0", pc_hold, pc_sel); end
    tick();
    checks++; if (id_valid !== 1'b0) begin failures++;
      $display("[TB] FAIL br_valid got=%b exp=0", id_valid); end
    if (taken) begin
      checks++; if (redir_pc !== 32'h400) begin failures++;
        $display("[TB] FAIL br_redir_pc got=%h exp=400", redir_pc); end
      apply(0, 1, 0, 0, 0, 0, 32'h208, 32'h7777);
      checks++; if (pc_sel !== 1'b1 || pc_hold !== 1'b0) begin failures++;
        $display("[TB] FAIL br_redirect got=%b/%b exp=1/0", pc_sel, pc_hold); end
      tick();
      checks++; if (id_valid !== 1'b0) begin failures++;
        $display("[TB] FAIL br_redirect_valid got=%b exp=0", id_valid); end
    end
    apply(0, 0, 0, 0, 0, 0, taken ? 32'h400 : 32'h208, 32'h1111);
    checks++; if (pc_sel !== 1'b0 || pc_hold !== 1'b0) begin failures++;
      $display("[TB] FAIL br_run got=%b/%b exp=0/0", pc_sel, pc_hold); end
    tick();
    checks++; if (id_pc !== (taken ? 32'h400 : 32'h208) || id_valid !== 1'b1) begin failures++;
      $display("[TB] FAIL br_next_fetch got=%h/%b exp=%h/1", id_pc, id_valid, taken ? 32'h400 : 32'h208); end
    checks++; if (stall_cnt !== 16'd3 || bubble_cnt !== (taken ? 16'd4 : 16'd3)) begin failures++;
      $display("[TB] FAIL br_cnt got=%0d/%0d exp=3/%0d", stall_cnt, bubble_cnt, taken ? 4 : 3); end
  endtask

  task automatic test_stall_resolve();
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 32'h500, 32'h2222);
    tick();
    apply(0, 1, 1, 1, 1, 32'h800, 32'h504, 32'h3333);
    checks++; if ({pc_hold, ex_bubble, pc_sel} !== 3'b110) begin failures++;
      $display("[TB] FAIL sr_comb got=%b exp=110", {pc_hold, ex_bubble, pc_sel}); end
    tick();
    checks++; if (redir_pc !== 32'h800 || id_pc !== 32'h500 || id_valid !== 1'b0) begin failures++;
      $display("[TB] FAIL sr_capture got=%h/%h/%b exp=800/500/0", redir_pc, id_pc, id_valid); end
    apply(0, 0, 1, 0, 0, 0, 32'h504, 32'h3333);
    checks++; if (pc_sel !== 1'b0 || pc_hold !== 1'b1) begin failures++;
      $display("[TB] FAIL sr_held got=%b/%b exp=0/1", pc_sel, pc_hold); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 32'h504, 32'h3333);
    checks++; if (pc_sel !== 1'b1 || pc_hold !== 1'b0) begin failures++;
      $display("[TB] FAIL sr_redirect got=%b/%b exp=1/0", pc_sel, pc_hold); end
    tick();
  endtask

  task automatic test_reset_mid_branch();
    do_reset();
    apply(0, 1, 0, 0, 0, 0, 32'h600, 32'h4444);
    tick();
    apply(0, 1, 0, 0, 0, 0, 32'h604, 32'h4444);
    tick();
    apply(1, 1, 0, 1, 1, 32'h900, 32'h604, 32'h4444);
    tick();
    apply(0, 0, 0, 0, 0, 0, 32'h700, 32'h8888);
    checks++; if ({pc_hold, pc_sel, ex_bubble} !== 3'b000) begin failures++;
      $display("[TB] FAIL rmb_comb got=%b exp=000", {pc_hold, pc_sel, ex_bubble}); end
    checks++; if (redir_pc !== 32'h0 || id_valid !== 1'b0 || stall_cnt !== 16'd0) begin failures++;
      $display("[TB] FAIL rmb_regs got=%h/%b/%0d exp=0/0/0", redir_pc, id_valid, stall_cnt); end
    tick();
    checks++; if (id_pc !== 32'h700 || id_valid !== 1'b1) begin failures++;
      $display("[TB] FAIL rmb_fetch got=%h/%b exp=700/1", id_pc, id_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 1, 0, 0, 0, 32'h40, 32'h1);
      tick();
    end
    checks++; if (s_stall_cnt !== 4'd15 || s_bubble_cnt !== 4'd15) begin failures++;
      $display("[TB] FAIL sat_small got=%0d/%0d exp=15/15", s_stall_cnt, s_bubble_cnt); end
    checks++; if (stall_cnt !== 16'd20 || bubble_cnt !== 16'd20) begin failures++;
      $display("[TB] FAIL sat_wide got=%0d/%0d exp=20/20", stall_cnt, bubble_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
            $urandom_range(2) == 0, $urandom_range(1) == 1, $urandom, $urandom, $urandom);
      checks++; if ({pc_hold, pc_sel, ex_bubble} !== {e_hold, e_sel, e_bubble}) begin failures++;
        $display("[TB] FAIL rnd_comb cycle=%0d got=%b exp=%b", i, {pc_hold, pc_sel, ex_bubble}, {e_hold, e_sel, e_bubble}); end
      checks++; if ({s_pc_hold, s_pc_sel, s_ex_bubble} !== {e_hold, e_sel, e_bubble}) begin failures++;
        $display("[TB] FAIL rnd_comb_small cycle=%0d got=%b exp=%b", i, {s_pc_hold, s_pc_sel, s_ex_bubble}, {e_hold, e_sel, e_bubble}); end
      tick();
      checks++; if (id_pc !== m_id_pc || id_inst !== m_id_inst || id_valid !== m_id_valid) begin failures++;
        $display("[TB] FAIL rnd_id cycle=%0d got=%h/%h/%b exp=%h/%h/%b", i, id_pc, id_inst, id_valid, m_id_pc, m_id_inst, m_id_valid); end
      checks++; if (redir_pc !== m_redir) begin failures++;
        $display("[TB] FAIL rnd_redir cycle=%0d got=%h exp=%h", i, redir_pc, m_redir); end
      checks++; if (stall_cnt !== sat16(m_stall) || bubble_cnt !== sat16(m_bubble)) begin failures++;
        $display("[TB] FAIL rnd_cnt cycle=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, bubble_cnt, sat16(m_stall), sat16(m_bubble)); end
      checks++; if (s_stall_cnt !== sat4(m_stall) || s_bubble_cnt !== sat4(m_bubble)) begin failures++;
        $display("[TB] FAIL rnd_cnt_small cycle=%0d got=%0d/%0d exp=%0d/%0d", i, s_stall_cnt, s_bubble_cnt, sat4(m_stall), sat4(m_bubble)); end
    end
  endtask

  initial begin
    m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_redir = 0;
    m_wait = 0; m_redirect = 0; m_stall = 0; m_bubble = 0;
    test_reset();
    test_fetch();
    test_id_stall();
    test_branch(1'b1);
    test_branch(1'b0);
    test_stall_resolve();
    test_reset_mid_branch();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
